// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the multi-channel countdown timer.
//   - command op codes carried on the 4-bit host op bus
//   - SEG_W: width of one reload payload segment ({data_in, addr})
//   - legal range of the counter width
`timescale 1ns/1ps
package timer_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_LOAD_LO        = 4'd0;
  localparam logic [OP_W-1:0] OP_LOAD_HI        = 4'd1;
  localparam logic [OP_W-1:0] OP_START_ONESHOT  = 4'd2;
  localparam logic [OP_W-1:0] OP_START_PERIODIC = 4'd3;
  localparam logic [OP_W-1:0] OP_STOP           = 4'd4;
  localparam logic [OP_W-1:0] OP_CLEAR          = 4'd5;

  localparam int SEG_W = 24;

  localparam int CNT_W_MIN = 25;
  localparam int CNT_W_MAX = 48;

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one countdown channel with reload register, one-shot or
// periodic mode, stop/restart and a sticky done flag.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   cmd_en      - a command addressed to this channel is present this cycle
//   op          - command code (timer_pkg OP_*)
//   payload     - 24-bit command payload
//   done        - sticky done flag (registered)
//   busy        - channel is counting (registered)
`timescale 1ns/1ps
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_en,
  input  logic [OP_W-1:0]  op,
  input  logic [SEG_W-1:0] payload,
  output logic             done,
  output logic             busy
);

  localparam int HI_W = CNT_W - SEG_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] reload_q, reload_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             periodic_q, periodic_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             done_event;

  // Countdown expiry this cycle, before any command is considered.
  assign done_event = busy_q && (cnt_q == '0);

  always_comb begin
    reload_d   = reload_q;
    cnt_d      = cnt_q;
    periodic_d = periodic_q;
    busy_d     = busy_q;
    done_d     = done_q;

    if (busy_q) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_ONE;
      end else begin
        done_d = 1'b1;
        if (periodic_q) cnt_d = reload_q;
        else            busy_d = 1'b0;
      end
    end

    // A command overrides the countdown update of the same cycle, except
    // that CLEAR never swallows a coincident done event.
    if (cmd_en) begin
      case (op)
        OP_LOAD_LO: reload_d[SEG_W-1:0] = payload;
        OP_LOAD_HI: reload_d[CNT_W-1:SEG_W] = payload[HI_W-1:0];
        OP_START_ONESHOT, OP_START_PERIODIC: begin
          cnt_d      = reload_q;
          periodic_d = (op == OP_START_PERIODIC);
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end
        OP_STOP: begin
          busy_d = 1'b0;
          cnt_d  = cnt_q;
          done_d = done_q;
        end
        OP_CLEAR: done_d = done_event;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_q   <= '0;
      cnt_q      <= '0;
      periodic_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      reload_q   <= reload_d;
      cnt_q      <= cnt_d;
      periodic_q <= periodic_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: rtl/multi_timer_interface.sv
// multi_timer_interface: NUM_CH independent countdown timers on the host
// command bus. Payload P = {data_in, addr}; commands with ch_sel >= NUM_CH
// are ignored.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   cs          - command strobe
//   op          - command code
//   ch_sel      - target channel
//   addr        - payload bits [7:0]
//   data_in     - payload bits [23:8]
//   rdy         - per-channel sticky done flags
//   busy        - per-channel running flags
//   irq         - OR of all done flags
`timescale 1ns/1ps
module multi_timer_interface
  import timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 48,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic [OP_W-1:0]   op,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [7:0]        addr,
  input  logic [15:0]       data_in,
  output logic [NUM_CH-1:0] rdy,
  output logic [NUM_CH-1:0] busy,
  output logic              irq
);

  logic [SEG_W-1:0]  payload;
  logic [NUM_CH-1:0] done_w;
  logic [NUM_CH-1:0] busy_w;

  assign payload = {data_in, addr};

  // ch_sel values >= NUM_CH match no channel, so they are dropped here.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic cmd_en;
    assign cmd_en = cs && (ch_sel == CH_W'(k));

    timer_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .cmd_en  (cmd_en),
      .op      (op),
      .payload (payload),
      .done    (done_w[k]),
      .busy    (busy_w[k])
    );
  end

  assign rdy  = done_w;
  assign busy = busy_w;
  assign irq  = |done_w;

endmodule

// File: tb/tb_multi_timer_interface.sv
`timescale 1ns/1ps
module tb_multi_timer_interface;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 48;
  localparam int CH_W   = 3;

  logic              clk;
  logic              rst_n;
  logic              cs;
  logic [3:0]        op;
  logic [CH_W-1:0]   ch_sel;
  logic [7:0]        addr;
  logic [15:0]       data_in;
  logic [NUM_CH-1:0] rdy;
  logic [NUM_CH-1:0] busy;
  logic              irq;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [CNT_W-1:0] BIG_R = 48'h1FF_FFFF;

  multi_timer_interface #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .CH_W   (CH_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs      (cs),
    .op      (op),
    .ch_sel  (ch_sel),
    .addr    (addr),
    .data_in (data_in),
    .rdy     (rdy),
    .busy    (busy),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one command; it executes on the next rising edge. Returns 1ns
  // after that edge.
  task automatic issue(input logic [3:0] o, input logic [CH_W-1:0] ch, input logic [23:0] p);
    cs      = 1'b1;
    op      = o;
    ch_sel  = ch;
    addr    = p[7:0];
    data_in = p[23:8];
    @(posedge clk);
    #1;
    cs = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b0; op = '0; ch_sel = '0; addr = '0; data_in = '0;
    #12;
    check("reset_rdy", rdy, 5'b00000);
    check("reset_busy", busy, 5'b00000);
    check("reset_irq", irq, 1'b0);
    rst_n = 1'b1;
    step(1);

    // One-shot ch0, R=5: done after edge T+6
    issue(4'd0, 3'd0, 24'd5);
    issue(4'd2, 3'd0, 24'd0);
    check("os_busy_start", busy, 5'b00001);
    step(5);
    check("os_rdy_T5", rdy, 5'b00000);
    check("os_busy_T5", busy, 5'b00001);
    step(1);
    check("os_rdy_T6", rdy, 5'b00001);
    check("os_busy_T6", busy, 5'b00000);
    check("os_irq_T6", irq, 1'b1);
    issue(4'd5, 3'd0, 24'd0);
    check("os_clear_rdy", rdy, 5'b00000);
    check("os_clear_irq", irq, 1'b0);

    // Periodic ch1, R=2: events every 3 cycles
    issue(4'd0, 3'd1, 24'd2);
    issue(4'd3, 3'd1, 24'd0);
    step(2);
    check("per_rdy_T2", rdy[1], 1'b0);
    step(1);
    check("per_rdy_T3", rdy[1], 1'b1);
    check("per_busy_T3", busy[1], 1'b1);
    issue(4'd5, 3'd1, 24'd0);
    check("per_clr1", rdy[1], 1'b0);
    step(1);
    check("per_rdy_T5", rdy[1], 1'b0);
    step(1);
    check("per_rdy_T6", rdy[1], 1'b1);
    issue(4'd5, 3'd1, 24'd0);
    check("per_clr2", rdy[1], 1'b0);
    step(2);
    check("per_rdy_T9", rdy[1], 1'b1);
    check("per_busy_T9", busy[1], 1'b1);
    issue(4'd4, 3'd1, 24'd0);
    check("per_stop_busy", busy[1], 1'b0);
    check("per_stop_rdy", rdy[1], 1'b1);
    issue(4'd5, 3'd1, 24'd0);
    check("per_final_clr", rdy, 5'b00000);

    // Wide reload ch2, stop after 10 cycles, restart
    issue(4'd0, 3'd2, 24'hFFFFFF);
    issue(4'd1, 3'd2, 24'h000001);
    check("wide_reload", dut.g_ch[2].u_ch.reload_q, BIG_R);
    issue(4'd2, 3'd2, 24'd0);
    check("wide_cnt_start", dut.g_ch[2].u_ch.cnt_q, BIG_R);
    step(9);
    issue(4'd4, 3'd2, 24'd0);
    check("wide_stop_busy", busy[2], 1'b0);
    check("wide_stop_cnt", dut.g_ch[2].u_ch.cnt_q, BIG_R - 48'd9);
    step(20);
    check("wide_hold_cnt", dut.g_ch[2].u_ch.cnt_q, BIG_R - 48'd9);
    check("wide_no_rdy", rdy[2], 1'b0);
    issue(4'd2, 3'd2, 24'd0);
    check("wide_restart_busy", busy[2], 1'b1);
    check("wide_restart_cnt", dut.g_ch[2].u_ch.cnt_q, BIG_R);
    step(3);
    check("wide_restart_cnt3", dut.g_ch[2].u_ch.cnt_q, BIG_R - 48'd3);
    issue(4'd4, 3'd2, 24'd0);
    check("wide_stop2_busy", busy, 5'b00000);

    // Periodic ch3, R=3: CLEAR coincident with event keeps rdy
    issue(4'd0, 3'd3, 24'd3);
    issue(4'd3, 3'd3, 24'd0);
    step(3);
    check("coinc_pre", rdy[3], 1'b0);
    issue(4'd5, 3'd3, 24'd0);
    check("coinc_keep", rdy[3], 1'b1);
    issue(4'd5, 3'd3, 24'd0);
    check("coinc_clr", rdy[3], 1'b0);
    step(2);
    check("coinc_T7", rdy[3], 1'b0);
    step(1);
    check("coinc_T8", rdy[3], 1'b1);
    issue(4'd4, 3'd3, 24'd0);
    check("coinc_stop", busy, 5'b00000);
    check("coinc_stop_rdy", rdy, 5'b01000);

    // R=0 on ch4: done one cycle after START
    issue(4'd2, 3'd4, 24'd0);
    check("r0_busy", busy[4], 1'b1);
    check("r0_rdy_pre", rdy[4], 1'b0);
    step(1);
    check("r0_rdy", rdy[4], 1'b1);
    check("r0_busy_end", busy[4], 1'b0);
    issue(4'd5, 3'd4, 24'd0);

    // Ignored commands
    for (int c = NUM_CH; c < 8; c++) begin
      issue(4'd2, CH_W'(c), 24'd0);
    end
    issue(4'd9, 3'd0, 24'd0);
    issue(4'd15, 3'd0, 24'd0);
    step(3);
    check("ign_rdy", rdy, 5'b01000);
    check("ign_busy", busy, 5'b00000);
    check("ign_reload0", dut.g_ch[0].u_ch.reload_q, 48'd5);

    // Async reset mid-count
    issue(4'd0, 3'd0, 24'd100);
    issue(4'd2, 3'd0, 24'd0);
    step(10);
    check("rst_pre_busy", busy[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_rdy", rdy, 5'b00000);
    check("rst_busy", busy, 5'b00000);
    check("rst_irq", irq, 1'b0);
    #3;
    rst_n = 1'b1;
    step(120);
    check("rst_after_rdy", rdy, 5'b00000);
    check("rst_after_busy", busy, 5'b00000);
    check("rst_after_irq", irq, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
